hms_timer: RTL
==============

Name: hms_timer

Overview:
- Parametrised hour/minute/second timer; successor to the separate wall-watch and cook-timer blocks.
- Runs as either an up-counting stopwatch or a down-counting countdown timer.
- Countdown mode includes preset reload and a self-clearing alarm.
- Sits between the debounced/edge-detected button front end and the FND/display formatter; all button inputs are single-cycle pulses.

Parameters:
CLK_DIV, 100_000_000, clk cycles per one-second tick (>=2; bench uses 10)
MAX_HOUR, 23, largest hour value before wrap (1..255)
ALARM_SEC, 10, seconds the alarm stays asserted before auto-clear; 0 = never auto-clear

Ports:
clk  in  1  system clock
reset_p  in  1  synchronous active-high reset
mode  in  1  0 = up (stopwatch), 1 = down (countdown); latched only on IDLE->RUN
btn_start  in  1  pulse: start / pause / resume
btn_clear  in  1  pulse: abort and zero
inc_sec  in  1  pulse: +1 second (edit)
inc_min  in  1  pulse: +1 minute (edit)
inc_hour  in  1  pulse: +1 hour (edit)
alarm_off  in  1  pulse: acknowledge alarm
sec  out  8  seconds 0..59
min  out  8  minutes 0..59
hour  out  8  hours 0..MAX_HOUR
running  out  1  high in RUN
alarm  out  1  high in ALARM
tick  out  1  one-cycle strobe on each one-second update in RUN

Behaviour:
- One clock: clk. Reset is synchronous and active-high on reset_p, sampled at the clk edge.
- Reset, including mid-run: state=IDLE; sec/min/hour/preset/divider/alarm-second count=0; running=alarm=tick=0; latched mode=0.
- Divider: counts 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - The edge where divider==CLK_DIV-1 is a "tick edge": divider returns to 0.
  - Divider is cleared on IDLE->RUN and on entry to ALARM.
  - Divider is held, not cleared, in PAUSE.
- Same-cycle priority: btn_clear > btn_start > alarm_off > inc_*.
- States:
  - IDLE:
    - inc_sec/inc_min/inc_hour each wrap independently, with no carry: 59->0, 59->0, MAX_HOUR->0. Simultaneous inc pulses are all applied.
    - btn_start: if mode=1 and time==0:00:00, ignore.
    - Otherwise on btn_start: latch mode; if mode=1, copy time to preset; go to RUN.
    - btn_clear: time=0, preset=0.
  - RUN: running=1; inc_* and alarm_off are ignored.
    - On a tick edge, tick=1 for that cycle and the time updates.
    - Up mode: sec+1, carry into min at 59, carry into hour at 59. MAX_HOUR:59:59 wraps to 0:00:00 and counting continues.
    - Down mode: sec-1, borrow from min, borrow from hour. If the decremented result is 0:00:00: on the same edge, time=0, state=ALARM, alarm=1, running=0.
    - btn_start -> PAUSE.
    - btn_clear -> IDLE with time=0; preset is kept.
  - PAUSE: time and divider frozen; inc_* ignored.
    - btn_start -> RUN, resuming the divider count.
    - btn_clear -> IDLE with time=0.
  - ALARM: alarm=1; time=0; btn_start ignored. The divider runs and counts elapsed alarm seconds.
    - alarm_off: time=preset, alarm=0, state=IDLE.
    - Any inc_*: alarm=0, state=IDLE, increment applied to 0:00:00 (no reload).
    - btn_clear: alarm=0, state=IDLE, time=0.
    - If ALARM_SEC>0 and ALARM_SEC tick edges elapse with no input: reload preset, alarm=0, state=IDLE.
- Output ranges: outputs never leave 0..59 / 0..59 / 0..MAX_HOUR. All outputs are registered.
- mode changes outside IDLE have no effect.

Test Plan:
1. Bench parameters: CLK_DIV=10, MAX_HOUR=23, ALARM_SEC=2. Up carry: set 0:59:59, mode=0, start -> tick on the 10th edge, time 1:00:00. Set 23:59:59, start -> 0:00:00 after 10 cycles, running stays 1.
2. Countdown borrow: set 1:00:00, mode=1, start -> 0:59:59 after 10 cycles. Set 0:00:02, start -> 0:00:01 after 10 cycles; at 20 cycles alarm=1, running=0, state ALARM.
3. Pause/resume: start up from 0:00:00, pause after 4 cycles, wait 30 cycles (time 0:00:00, tick never asserted), resume -> tick exactly 6 cycles later, time 0:00:01.
4. Alarm exits: countdown from 0:00:03 expires, alarm_off -> alarm=0, time 0:00:03, IDLE. Repeat with no input -> auto-clear 20 cycles after alarm rises, time 0:00:03. Repeat with inc_min in ALARM -> 0:01:00, alarm=0.
5. Edge cases: mode=1 at 0:00:00 + btn_start -> stays IDLE. btn_clear+btn_start in the same RUN cycle -> IDLE, time 0. inc_sec+inc_min in the same cycle at 0:59:59 (IDLE) -> 0:00:00, hour unchanged (no carry).
6. Reset mid-operation: reset_p asserted in RUN at 0:12:34 -> next edge all outputs 0, IDLE. Subsequent start with mode=1 and time 0 is ignored.

Source files
------------

// File: rtl/hms_timer.sv
// Hour/minute/second timer: up-counting stopwatch or down-counting countdown
// with preset reload and a self-clearing alarm. All outputs are registered.
module hms_timer #(
  parameter int unsigned CLK_DIV   = 100_000_000,
  parameter int unsigned MAX_HOUR  = 23,
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       mode,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       alarm_off,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       running,
  output logic       alarm,
  output logic       tick
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  // Two extra codes keep the counter at least one bit wide when ALARM_SEC is 0.
  localparam int unsigned ACNT_W = $clog2(ALARM_SEC + 2);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]        SEC_LAST   = 8'd59;
  localparam logic [7:0]        HOUR_LAST  = 8'(MAX_HOUR);
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'((ALARM_SEC > 0) ? ALARM_SEC - 1 : 0);
  localparam logic              ALARM_AUTO = (ALARM_SEC > 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] last);
    return (v == last) ? 8'd0 : v + 8'd1;
  endfunction

  logic [1:0]        state, state_n;
  logic [7:0]        sec_n, min_n, hour_n;
  logic [7:0]        pre_sec, pre_min, pre_hour;
  logic [7:0]        pre_sec_n, pre_min_n, pre_hour_n;
  logic              mode_q, mode_n;
  logic [DIV_W-1:0]  divider, div_n;
  logic [ACNT_W-1:0] acnt, acnt_n;
  logic              tick_n;

  logic              div_wrap;
  logic [DIV_W-1:0]  div_inc;
  logic              time_zero;
  logic              at_one;
  logic              any_inc;
  logic [7:0]        sec_e, min_e, hour_e;

  assign div_wrap  = (divider == DIV_LAST);
  assign div_inc   = div_wrap ? '0 : divider + DIV_W'(1);
  assign time_zero = (sec == 8'd0) && (min == 8'd0) && (hour == 8'd0);
  assign at_one    = (sec == 8'd1) && (min == 8'd0) && (hour == 8'd0);
  assign any_inc   = inc_sec | inc_min | inc_hour;

  // Edit increments wrap each field on its own; no carry between fields.
  assign sec_e  = inc_sec  ? wrap_inc(sec,  SEC_LAST)  : sec;
  assign min_e  = inc_min  ? wrap_inc(min,  SEC_LAST)  : min;
  assign hour_e = inc_hour ? wrap_inc(hour, HOUR_LAST) : hour;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_n    = state;
    sec_n      = sec;
    min_n      = min;
    hour_n     = hour;
    pre_sec_n  = pre_sec;
    pre_min_n  = pre_min;
    pre_hour_n = pre_hour;
    mode_n     = mode_q;
    div_n      = divider;
    acnt_n     = acnt;
    tick_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (btn_clear) begin
          {hour_n, min_n, sec_n}             = '0;
          {pre_hour_n, pre_min_n, pre_sec_n} = '0;
        end else if (btn_start && !(mode && time_zero)) begin
          mode_n  = mode;
          div_n   = '0;
          state_n = S_RUN;
          if (mode) {pre_hour_n, pre_min_n, pre_sec_n} = {hour, min, sec};
        end else begin
          sec_n  = sec_e;
          min_n  = min_e;
          hour_n = hour_e;
        end
      end

      S_RUN: begin
        if (btn_clear) begin
          {hour_n, min_n, sec_n} = '0;
          div_n   = '0;
          state_n = S_IDLE;
        end else if (btn_start) begin
          state_n = S_PAUSE;
        end else begin
          div_n = div_inc;
          if (div_wrap) begin
            tick_n = 1'b1;
            if (!mode_q) begin
              if (sec == SEC_LAST) begin
                sec_n = 8'd0;
                if (min == SEC_LAST) begin
                  min_n  = 8'd0;
                  hour_n = wrap_inc(hour, HOUR_LAST);
                end else begin
                  min_n = min + 8'd1;
                end
              end else begin
                sec_n = sec + 8'd1;
              end
            end else if (at_one) begin
              // Countdown reaches zero: raise the alarm on this same edge.
              {hour_n, min_n, sec_n} = '0;
              div_n   = '0;
              acnt_n  = '0;
              state_n = S_ALARM;
            end else if (sec != 8'd0) begin
              sec_n = sec - 8'd1;
            end else begin
              sec_n = SEC_LAST;
              if (min != 8'd0) begin
                min_n = min - 8'd1;
              end else begin
                min_n  = SEC_LAST;
                hour_n = hour - 8'd1;
              end
            end
          end
        end
      end

      S_PAUSE: begin
        if (btn_clear) begin
          {hour_n, min_n, sec_n} = '0;
          div_n   = '0;
          state_n = S_IDLE;
        end else if (btn_start) begin
          state_n = S_RUN;
        end
      end

      S_ALARM: begin
        if (btn_clear) begin
          {hour_n, min_n, sec_n} = '0;
          state_n = S_IDLE;
        end else if (alarm_off) begin
          {hour_n, min_n, sec_n} = {pre_hour, pre_min, pre_sec};
          state_n = S_IDLE;
        end else if (any_inc) begin
          // Time is already zero here, so the edit applies to 0:00:00.
          sec_n   = sec_e;
          min_n   = min_e;
          hour_n  = hour_e;
          state_n = S_IDLE;
        end else begin
          div_n = div_inc;
          if (div_wrap && ALARM_AUTO) begin
            if (acnt == ALARM_LAST) begin
              {hour_n, min_n, sec_n} = {pre_hour, pre_min, pre_sec};
              state_n = S_IDLE;
            end else begin
              acnt_n = acnt + ACNT_W'(1);
            end
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
    if (reset_p) begin
      state    <= S_IDLE;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      pre_sec  <= '0;
      pre_min  <= '0;
      pre_hour <= '0;
      mode_q   <= 1'b0;
      divider  <= '0;
      acnt     <= '0;
      running  <= 1'b0;
      alarm    <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_n;
      sec      <= sec_n;
      min      <= min_n;
      hour     <= hour_n;
      pre_sec  <= pre_sec_n;
      pre_min  <= pre_min_n;
      pre_hour <= pre_hour_n;
      mode_q   <= mode_n;
      divider  <= div_n;
      acnt     <= acnt_n;
      running  <= (state_n == S_RUN);
      alarm    <= (state_n == S_ALARM);
      tick     <= tick_n;
    end
  end

endmodule
